// File: rtl/pc_fetch_unit.sv
// Program-counter stage for instruction fetch: holds the PC, selects the next PC,
// advances only on a completed fetch handshake, traps on misaligned targets.
module pc_fetch_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            stall,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [XLEN-1:0] PCTarget,
    output logic            misalign_err,
    output logic [31:0]     instret
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        TRAP = 2'b10
    } state_e;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instret_q, instret_d;
    logic            err_q, err_d;
    logic            req_q, req_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] next_pc;
    logic            advance;
    logic            misaligned;

    always_comb begin
        pc_plus4  = pc_q + PC_STEP;
        pc_target = pc_q + ImmExt;

        next_pc = pc_q;
        unique case (PCSrc)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = pc_target;
            2'b10:   next_pc = {ALUResult[XLEN-1:1], 1'b0};
            default: next_pc = pc_q;
        endcase

        // PCSrc=11 is a hold: it never counts as an advance, so it cannot trap either.
        advance    = (state_q == RUN) && imem_ready && !stall && (PCSrc != 2'b11);
        misaligned = (next_pc[1:0] != 2'b00);
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        err_d     = err_q;
        req_d     = req_q;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                req_d   = 1'b1;
            end
            RUN: begin
                if (advance) begin
                    if (misaligned) begin
                        state_d = TRAP;
                        err_d   = 1'b1;
                        req_d   = 1'b0;
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 32'd1;
                    end
                end
            end
            TRAP: begin
                req_d = 1'b0;
                err_d = 1'b1;
            end
            default: begin
                state_d = BOOT;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            instret_q <= '0;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            err_q     <= err_d;
            req_q     <= req_d;
        end
    end

    assign imem_req     = req_q;
    assign PC           = pc_q;
    assign PCPlus4      = pc_plus4;
    assign PCTarget     = pc_target;
    assign misalign_err = err_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: two instances (default reset PC and a wrap-test
// reset PC) share stimulus; a behavioural model predicts state after each edge.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] ImmExt = '0;
    logic [31:0] ALUResult = '0;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b0;

    logic        req0, req1, err0, err1;
    logic [31:0] pc0, pc1, p40, p41, tg0, tg1, ir0, ir1;

    always #5 clk = ~clk;

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .PCSrc(PCSrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
        .stall(stall), .imem_ready(imem_ready), .imem_req(req0), .PC(pc0),
        .PCPlus4(p40), .PCTarget(tg0), .misalign_err(err0), .instret(ir0)
    );

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .PCSrc(PCSrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
        .stall(stall), .imem_ready(imem_ready), .imem_req(req1), .PC(pc1),
        .PCPlus4(p41), .PCTarget(tg1), .misalign_err(err1), .instret(ir1)
    );

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] p4;
        logic [31:0] tgt;
        logic        err;
        logic        req;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: architectural state only (booting / running / trapped).
    logic [31:0] m_pc[2];
    logic [31:0] m_ir[2];
    bit          m_boot[2];
    bit          m_trap[2];
    logic [31:0] m_rpc[2];

    task automatic check32(input string name, input int idx, input logic [31:0] act,
                           input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[dut%0d] at %0t: got %h want %h", name, idx, $time, act, exp);
        end
    endtask

    // Monitor: each negedge, compare every prediction queued since the last edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check32("PC",       e.idx, e.idx == 0 ? pc0  : pc1,  e.pc);
            check32("instret",  e.idx, e.idx == 0 ? ir0  : ir1,  e.ir);
            check32("PCPlus4",  e.idx, e.idx == 0 ? p40  : p41,  e.p4);
            check32("PCTarget", e.idx, e.idx == 0 ? tg0  : tg1,  e.tgt);
            check32("misalign", e.idx, {31'd0, e.idx == 0 ? err0 : err1}, {31'd0, e.err});
            check32("imem_req", e.idx, {31'd0, e.idx == 0 ? req0 : req1}, {31'd0, e.req});
        end
    end

    task automatic step(input bit r, input logic [1:0] src, input logic [31:0] imm,
                        input logic [31:0] alu, input bit st, input bit rdy);
        logic [31:0] tgt;
        @(negedge clk);
        #1;
        rst = r; PCSrc = src; ImmExt = imm; ALUResult = alu; stall = st; imem_ready = rdy;
        for (int d = 0; d < 2; d++) begin
            if (!r) begin
                m_pc[d] = m_rpc[d]; m_ir[d] = 0; m_boot[d] = 1; m_trap[d] = 0;
            end else if (m_boot[d]) begin
                m_boot[d] = 0;
            end else if (!m_trap[d] && rdy && !st && src != 2'd3) begin
                case (src)
                    2'd0:    tgt = m_pc[d] + 32'd4;
                    2'd1:    tgt = m_pc[d] + imm;
                    default: tgt = alu & ~32'd1;
                endcase
                if (tgt % 4 != 0) m_trap[d] = 1;
                else begin
                    m_pc[d] = tgt;
                    m_ir[d] = m_ir[d] + 1;
                end
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            e.idx = d; e.pc = m_pc[d]; e.ir = m_ir[d];
            e.p4 = m_pc[d] + 32'd4; e.tgt = m_pc[d] + imm;
            e.err = m_trap[d]; e.req = !m_boot[d] && !m_trap[d];
            sb.push_back(e);
        end
    endtask

    initial begin
        m_rpc[0] = 32'h0000_0000;
        m_rpc[1] = 32'hFFFF_FFFC;

        // Reset for 3 cycles, then BOOT (req=0) for one cycle.
        repeat (3) step(0, 2'd0, 0, 0, 0, 1);
        step(1, 2'd0, 0, 0, 0, 1);
        // Sequential fetch 4,8,12,16; the wrap instance goes FFFFFFFC -> 0 first.
        repeat (4) step(1, 2'd0, 0, 0, 0, 1);
        // Branch back by 8, then JALR with bit 0 cleared.
        step(1, 2'd1, 32'hFFFF_FFF8, 0, 0, 1);
        step(1, 2'd2, 0, 32'h0000_0101, 0, 1);
        // Handshake holds, then a single advance, then reserved select holds.
        repeat (2) step(1, 2'd0, 0, 0, 0, 0);
        step(1, 2'd0, 0, 0, 1, 1);
        step(1, 2'd2, 0, 32'h0000_0003, 1, 1);
        step(1, 2'd0, 0, 0, 0, 1);
        step(1, 2'd3, 0, 0, 0, 1);
        // Return to PC=8, then misaligned branch traps and stays trapped.
        step(1, 2'd1, 32'h0000_0008 - 32'h0000_0104, 0, 0, 1);
        step(1, 2'd1, 32'h0000_0006, 0, 0, 1);
        repeat (5) step(1, 2'd0, 0, 0, 0, 1);
        step(0, 2'd0, 0, 0, 0, 1);
        step(1, 2'd0, 0, 0, 0, 1);
        // Wrap on the second instance: one advance from FFFFFFFC.
        step(1, 2'd0, 0, 0, 0, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] imm, alu;
            imm = $urandom;
            alu = $urandom;
            if ($urandom_range(7) != 0) imm = imm & ~32'd3;
            if ($urandom_range(7) != 0) alu = alu & ~32'd3;
            step($urandom_range(39) != 0, 2'($urandom_range(3)), imm, alu,
                 $urandom_range(3) == 0, $urandom_range(3) != 0);
        end

        @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
